exe_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the Execute stage, directly downstream of the Decode/Execute pipeline register. It consumes RD1E/RD2E-derived operands and a 2-bit operation code and runs a radix-2 shift/add (multiply) or restoring (divide) sequence. It holds the architectural HI/LO registers and reports busy to the hazard unit, which stalls MFHI/MFLO and new multiply/divide issue until done.

---
 rtl/exe_muldiv_unit_pkg.sv | 25 ++
 rtl/exe_muldiv_sign_fix.sv | 13 +
 rtl/exe_muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_unit_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit:
// op encodings, FSM state encoding and small op-decode helpers.
package exe_muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  function automatic logic md_is_signed(input logic [1:0] md_op);
    return (md_op == MD_MULT) || (md_op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] md_op);
    return (md_op == MD_DIV) || (md_op == MD_DIVU);
  endfunction

endpackage

// File: rtl/exe_muldiv_sign_fix.sv
// Conditional two's-complement negate: absolute value on operand entry,
// sign restoration on result exit.
module exe_muldiv_sign_fix #(
  parameter int width = 32
) (
  input  logic [width-1:0] value,
  input  logic             negate,
  output logic [width-1:0] result
);

  assign result = negate ? (~value + {{(width-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit holding HI/LO.
// One result bit per RUN cycle; sign handled as magnitude + fix-up.
//
// state | meaning
// IDLE  | waiting for start; operands and op latched on start
// PREP  | take operand magnitudes, record signs, clear accumulator
// RUN   | one shift/add or shift/subtract iteration per cycle
// FIX   | sign-correct result and write HI/LO, pulse done
module exe_muldiv_unit
  import exe_muldiv_unit_pkg::*;
#(
  parameter int data_size = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [data_size-1:0] SrcAE,
  input  logic [data_size-1:0] SrcBE,
  input  logic                 abort,
  output logic [data_size-1:0] HI,
  output logic [data_size-1:0] LO,
  output logic                 busy,
  output logic                 done
);

  localparam int cnt_w = $clog2(data_size) + 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(data_size - 1);

  md_state_t state, state_next;

  logic [1:0]             op_q;
  logic [data_size-1:0]   a_q, b_q;
  logic [data_size-1:0]   mq, dv;
  logic [2*data_size-1:0] acc;
  logic                   res_sign, rem_sign;
  logic [cnt_w-1:0]       cnt;

  logic                   op_signed, op_div;
  logic [data_size-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*data_size-1:0] prod_fix;
  logic [2*data_size-1:0] acc_next;
  logic [data_size-1:0]   mq_next;
  logic [data_size:0]     div_shift;
  logic [data_size+1:0]   div_diff;

  assign op_signed = md_is_signed(op_q);
  assign op_div    = md_is_div(op_q);
  assign busy      = (state != ST_IDLE);

  exe_muldiv_sign_fix #(.width(data_size)) u_abs_a (
    .value(a_q), .negate(op_signed & a_q[data_size-1]), .result(a_mag));
  exe_muldiv_sign_fix #(.width(data_size)) u_abs_b (
    .value(b_q), .negate(op_signed & b_q[data_size-1]), .result(b_mag));
  exe_muldiv_sign_fix #(.width(2*data_size)) u_fix_prod (
    .value(acc), .negate(res_sign), .result(prod_fix));
  exe_muldiv_sign_fix #(.width(data_size)) u_fix_quo (
    .value(mq), .negate(res_sign), .result(quo_fix));
  exe_muldiv_sign_fix #(.width(data_size)) u_fix_rem (
    .value(acc[data_size-1:0]), .negate(rem_sign), .result(rem_fix));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_PREP;
      ST_PREP: state_next = ST_RUN;
      ST_RUN:  if (cnt == cnt_last) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_next = ST_IDLE;
  end

  // Multiply walks the multiplier MSB-first in mq; divide shifts dividend
  // bits out of mq's top while quotient bits enter at its bottom.
  always_comb begin
    acc_next  = acc;
    mq_next   = mq << 1;
    div_shift = {acc[data_size-1:0], mq[data_size-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, dv};
    if (op_div) begin
      if (!div_diff[data_size+1]) begin
        acc_next   = {{(data_size-1){1'b0}}, div_diff[data_size:0]};
        mq_next[0] = 1'b1;
      end else begin
        acc_next = {{(data_size-1){1'b0}}, div_shift};
      end
    end else begin
      acc_next = (acc << 1) + (mq[data_size-1] ? {{data_size{1'b0}}, dv} : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mq       <= '0;
      dv       <= '0;
      acc      <= '0;
      res_sign <= 1'b0;
      rem_sign <= 1'b0;
      cnt      <= '0;
      HI       <= '0;
      LO       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_FIX) && !abort;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= SrcAE;
            b_q  <= SrcBE;
          end
        end
        ST_PREP: begin
          mq       <= op_div ? a_mag : b_mag;
          dv       <= op_div ? b_mag : a_mag;
          res_sign <= op_signed & (a_q[data_size-1] ^ b_q[data_size-1]);
          rem_sign <= op_signed & a_q[data_size-1];
          acc      <= '0;
          cnt      <= '0;
        end
        ST_RUN: begin
          acc <= acc_next;
          mq  <= mq_next;
          cnt <= cnt + cnt_w'(1);
        end
        ST_FIX: begin
          if (!abort) begin
            if (!op_div) begin
              {HI, LO} <= prod_fix;
            end else if (b_q == '0) begin
              // Divide by zero overrides sign fix-up regardless of op sign.
              HI <= a_q;
              LO <= '1;
            end else begin
              HI <= rem_fix;
              LO <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed + randomized bench for exe_muldiv_unit against an arithmetic
// reference model built on longint multiply, divide and modulo.
module tb_exe_muldiv_unit;
  import exe_muldiv_unit_pkg::*;

  localparam int N = 32;
  localparam int LAT = N + 2;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [1:0]   op;
  logic [N-1:0] src_a, src_b, hi, lo;
  logic         busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_muldiv_unit #(.data_size(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .SrcAE(src_a), .SrcBE(src_b), .abort(abort),
    .HI(hi), .LO(lo), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (o)
      MD_MULT:  p = sa * sb;
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and follow it to done; inject_at >= 0 pulses start
  // again that many edges after acceptance, which must be ignored.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input int inject_at);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int cyc, busy_cnt;
    bit stable;
    exp = ref_result(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    hi0 = hi; lo0 = lo;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    cyc = 0; busy_cnt = 0; stable = 1'b1;
    @(negedge clk);
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      start = (cyc == inject_at);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      @(negedge clk);
    end
    check({tag, " latency"}, cyc, LAT);
    check({tag, " busy_cycles"}, busy_cnt, LAT);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " hilo_stable"}, stable, 1);
    check({tag, " hilo"}, {hi, lo}, exp);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    bit saw_done;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    reset = 1'b0;

    issue(MD_MULT, 32'h7, 32'hFFFF_FFFD, "mult_7x-3", -1);
    check("mult_7x-3 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1);
    check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1m1", -1);
    check("mult_m1m1 const", {hi, lo}, 64'h0000_0000_0000_0001);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2, "div_-7_2", -1);
    check("div_-7_2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1);
    check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(MD_DIVU, 32'd100, 32'h0, "divu_by0", 10);
    check("divu_by0 const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    issue(MD_DIV, 32'hFFFF_FF00, 32'h0, "div_neg_by0", -1);

    // Abort mid-RUN leaves the previous HI/LO untouched.
    issue(MD_DIVU, 32'h451, 32'h20, "prior", -1);
    check("prior const", {hi, lo}, 64'h0000_0011_0000_0022);
    @(negedge clk);
    start = 1'b1; op = MD_MULT; src_a = $urandom; src_b = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort no_done", saw_done, 0);
    issue(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, "after_abort", -1);

    // Reset mid-RUN discards the result; reset held blocks start.
    @(negedge clk);
    start = 1'b1; op = MD_DIV; src_a = 32'h1234; src_b = 32'h7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid hi", hi, 0);
    check("rst_mid lo", lo, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid done", done, 0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_held busy", busy, 0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_release busy", busy, 0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      issue(ro, ra, rb, "rand", -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
